// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl: drives one four-in-a-row detector with an N-bit pattern
// and tallies its z detections (count, first hit position).
module seq_stream_ctrl #(
    parameter int N  = 16,
    parameter int IW = 4,
    parameter int CW = 5
) (
    input  logic          Clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [N-1:0]  pattern,
    input  logic          z_in,
    output logic          det_reset_n,
    output logic          w,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] hit_count,
    output logic          any_hit,
    output logic [IW-1:0] first_hit
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [CW-1:0] HIT_MAX  = '1;

    state_e        state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] hit_count_q, hit_count_d;
    logic          any_hit_q, any_hit_d;
    logic [IW-1:0] first_hit_q, first_hit_d;

    logic          hit;
    logic [IW-1:0] hit_pos;

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            hit_count_q <= '0;
            any_hit_q   <= 1'b0;
            first_hit_q <= '1;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            hit_count_q <= hit_count_d;
            any_hit_q   <= any_hit_d;
            first_hit_q <= first_hit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        hit_count_d = hit_count_q;
        any_hit_d   = any_hit_q;
        first_hit_d = first_hit_q;
        hit         = 1'b0;
        hit_pos     = LAST_IDX;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_STREAM;
                    shreg_d     = pattern;
                    idx_d       = '0;
                    hit_count_d = '0;
                    any_hit_d   = 1'b0;
                    first_hit_d = '1;
                end
            end
            S_STREAM: begin
                shreg_d = shreg_q >> 1;
                idx_d   = idx_q + IW'(1);
                // z lags w by one edge, so it reports on the previous bit
                hit     = z_in && (idx_q != '0);
                hit_pos = idx_q - IW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end
            end
            S_DRAIN: begin
                hit     = z_in;
                hit_pos = LAST_IDX;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (hit) begin
            if (hit_count_q != HIT_MAX) begin
                hit_count_d = hit_count_q + CW'(1);
            end
            if (!any_hit_q) begin
                any_hit_d   = 1'b1;
                first_hit_d = hit_pos;
            end
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign det_reset_n = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign w           = (state_q == S_STREAM) && shreg_q[0];
    assign hit_count   = hit_count_q;
    assign any_hit     = any_hit_q;
    assign first_hit   = first_hit_q;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// tb_seq_stream_ctrl: random and directed runs against a pattern-level model,
// with a behavioural four-in-a-row detector closing the loop on each DUT.
module tb_seq_stream_ctrl;

    localparam int N = 16;

    logic         Clock   = 1'b0;
    logic         reset_n = 1'b0;
    logic         start   = 1'b0;
    logic [N-1:0] pattern = '0;

    logic       z_a = 1'b0, z_b = 1'b0;
    logic       drn_a, w_a, busy_a, done_a, any_a;
    logic [4:0] hc_a;
    logic [3:0] fh_a;
    logic       drn_b, w_b, busy_b, done_b, any_b;
    logic [2:0] hc_b;
    logic [3:0] fh_b;

    int errors = 0;
    int checks = 0;

    logic w_obs    [0:63];
    logic drn_obs  [0:63];
    logic busy_obs [0:63];

    int   run_a = 0, run_b = 0;
    logic last_a = 1'b0, last_b = 1'b0;

    always #5 Clock = ~Clock;

    seq_stream_ctrl #(.N(N), .IW(4), .CW(5)) dut_a (
        .Clock(Clock), .reset_n(reset_n), .start(start), .pattern(pattern),
        .z_in(z_a), .det_reset_n(drn_a), .w(w_a), .busy(busy_a),
        .done(done_a), .hit_count(hc_a), .any_hit(any_a), .first_hit(fh_a)
    );

    seq_stream_ctrl #(.N(N), .IW(4), .CW(3)) dut_b (
        .Clock(Clock), .reset_n(reset_n), .start(start), .pattern(pattern),
        .z_in(z_b), .det_reset_n(drn_b), .w(w_b), .busy(busy_b),
        .done(done_b), .hit_count(hc_b), .any_hit(any_b), .first_hit(fh_b)
    );

    // Detector: z=1 once the last four sampled w bits are equal.
    always @(posedge Clock) begin
        if (!drn_a) begin
            run_a <= 0;
            z_a   <= 1'b0;
        end else begin
            run_a  <= (run_a > 0 && w_a == last_a) ? run_a + 1 : 1;
            last_a <= w_a;
            z_a    <= (run_a >= 3 && w_a == last_a);
        end
    end

    always @(posedge Clock) begin
        if (!drn_b) begin
            run_b <= 0;
            z_b   <= 1'b0;
        end else begin
            run_b  <= (run_b > 0 && w_b == last_b) ? run_b + 1 : 1;
            last_b <= w_b;
            z_b    <= (run_b >= 3 && w_b == last_b);
        end
    end

    function automatic void ref_hits(input logic [N-1:0] p,
                                     output int cnt, output int first);
        int run;
        cnt   = 0;
        first = 15;
        run   = 0;
        for (int k = 0; k < N; k++) begin
            if (k > 0 && p[k] == p[k-1]) run++;
            else run = 1;
            if (run >= 4) begin
                if (cnt == 0) first = k;
                cnt++;
            end
        end
    endfunction

    task automatic do_run(input logic [N-1:0] pat, output int lat);
        lat = -1;
        @(negedge Clock);
        start   = 1'b1;
        pattern = pat;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clock);
            if (n == 1) begin
                start   = 1'b0;
                pattern = N'($urandom);
            end
            w_obs[n]    = w_a;
            drn_obs[n]  = drn_a;
            busy_obs[n] = busy_a;
            if (done_a === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        start   = 1'b1;
        pattern = 16'hFFFF;
        repeat (3) @(negedge Clock);
        checks++;
        if (drn_a !== 1'b0 || w_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_det: drn=%b w=%b want 0 0", drn_a, w_a);
        end
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: busy=%b done=%b want 0 0", busy_a, done_a);
        end
        checks++;
        if (hc_a !== 5'd0 || any_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_hits: hc=%0d any=%b want 0 0", hc_a, any_a);
        end
        checks++;
        if (fh_a !== 4'hF || fh_b !== 4'hF) begin
            errors++;
            $display("FAIL reset_first: a=%h b=%h want f f", fh_a, fh_b);
        end
        start   = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge Clock);
        checks++;
        if (busy_a !== 1'b0 || drn_a !== 1'b0 || hc_b !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b drn=%b hcb=%0d want 0 0 0",
                     busy_a, drn_a, hc_b);
        end
    endtask

    task automatic test_pattern(input logic [N-1:0] pat);
        int cnt, first, lat, sat;
        ref_hits(pat, cnt, first);
        sat = (cnt > 7) ? 7 : cnt;
        do_run(pat, lat);
        checks++;
        if (lat != N + 2) begin
            errors++;
            $display("FAIL done_latency pat=%h: got %0d want %0d", pat, lat, N + 2);
        end
        checks++;
        if (hc_a !== 5'(cnt)) begin
            errors++;
            $display("FAIL hit_count pat=%h: got %0d want %0d", pat, hc_a, cnt);
        end
        checks++;
        if (any_a !== (cnt > 0)) begin
            errors++;
            $display("FAIL any_hit pat=%h: got %b want %b", pat, any_a, cnt > 0);
        end
        checks++;
        if (fh_a !== 4'(first)) begin
            errors++;
            $display("FAIL first_hit pat=%h: got %0d want %0d", pat, fh_a, first);
        end
        checks++;
        if (hc_b !== 3'(sat) || fh_b !== 4'(first)) begin
            errors++;
            $display("FAIL sat_count pat=%h: got %0d/%0d want %0d/%0d",
                     pat, hc_b, fh_b, sat, first);
        end
        checks++;
        if (drn_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL done_ctl pat=%h: drn=%b busy=%b want 0 1",
                     pat, drn_a, busy_a);
        end
        for (int n = 1; n <= N; n++) begin
            checks++;
            if (w_obs[n] !== pat[n-1] || drn_obs[n] !== 1'b1 || busy_obs[n] !== 1'b1) begin
                errors++;
                $display("FAIL stream_bit%0d pat=%h: w=%b drn=%b busy=%b want %b 1 1",
                         n - 1, pat, w_obs[n], drn_obs[n], busy_obs[n], pat[n-1]);
            end
        end
        checks++;
        if (w_obs[N+1] !== 1'b0 || drn_obs[N+1] !== 1'b1) begin
            errors++;
            $display("FAIL drain pat=%h: w=%b drn=%b want 0 1",
                     pat, w_obs[N+1], drn_obs[N+1]);
        end
        @(negedge Clock);
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || drn_a !== 1'b0 ||
            hc_a !== 5'(cnt) || fh_a !== 4'(first)) begin
            errors++;
            $display("FAIL idle_hold pat=%h: done=%b busy=%b drn=%b hc=%0d fh=%0d",
                     pat, done_a, busy_a, drn_a, hc_a, fh_a);
        end
    endtask

    task automatic test_ignore_start;
        int dones, done_at, busy_late;
        logic [4:0] hc_at;
        logic [3:0] fh_at;
        dones     = 0;
        done_at   = -1;
        busy_late = 0;
        hc_at     = '0;
        fh_at     = '0;
        @(negedge Clock);
        start   = 1'b1;
        pattern = 16'hFFFF;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clock);
            start   = (n == 3 || n == 8 || n == 15 || n == 17 || n == 18);
            pattern = 16'h0F0F;
            if (done_a === 1'b1) begin
                dones++;
                done_at = n;
                hc_at   = hc_a;
                fh_at   = fh_a;
            end
            if (n > N + 2 && busy_a !== 1'b0) busy_late++;
        end
        start = 1'b0;
        checks++;
        if (dones != 1 || done_at != N + 2) begin
            errors++;
            $display("FAIL ignore_done: pulses=%0d at=%0d want 1 at %0d",
                     dones, done_at, N + 2);
        end
        checks++;
        if (hc_at !== 5'd13 || fh_at !== 4'd3) begin
            errors++;
            $display("FAIL ignore_result: hc=%0d fh=%0d want 13 3", hc_at, fh_at);
        end
        checks++;
        if (busy_late != 0) begin
            errors++;
            $display("FAIL ignore_queue: busy cycles after done=%0d want 0", busy_late);
        end
    endtask

    task automatic test_abort;
        int seen;
        seen = 0;
        @(negedge Clock);
        start   = 1'b1;
        pattern = 16'hFFFF;
        for (int n = 1; n <= 7; n++) begin
            @(negedge Clock);
            if (n == 1) start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || drn_a !== 1'b0 || w_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_ctl: busy=%b drn=%b w=%b done=%b want 0 0 0 0",
                     busy_a, drn_a, w_a, done_a);
        end
        checks++;
        if (hc_a !== 5'd0 || any_a !== 1'b0 || fh_a !== 4'hF) begin
            errors++;
            $display("FAIL abort_results: hc=%0d any=%b fh=%h want 0 0 f",
                     hc_a, any_a, fh_a);
        end
        repeat (2) @(negedge Clock);
        reset_n = 1'b1;
        repeat (24) begin
            @(negedge Clock);
            if (done_a !== 1'b0 || busy_a !== 1'b0 || done_b !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: active cycles=%0d want 0", seen);
        end
        test_pattern(16'h0000);
    endtask

    task automatic test_back_to_back;
        int cnt1, f1, cnt2, f2, lat;
        logic [N-1:0] p2;
        p2 = N'($urandom);
        ref_hits(16'h000F, cnt1, f1);
        ref_hits(p2, cnt2, f2);
        lat = -1;
        @(negedge Clock);
        start   = 1'b1;
        pattern = 16'h000F;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clock);
            if (done_a === 1'b1) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat != N + 2 || hc_a !== 5'(cnt1)) begin
            errors++;
            $display("FAIL b2b_run1: lat=%0d hc=%0d want %0d %0d", lat, hc_a, N + 2, cnt1);
        end
        pattern = p2;
        @(negedge Clock);
        checks++;
        if (busy_a !== 1'b0 || hc_a !== 5'(cnt1) || fh_a !== 4'(f1) || any_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold: busy=%b hc=%0d fh=%0d want 0 %0d %0d",
                     busy_a, hc_a, fh_a, cnt1, f1);
        end
        @(negedge Clock);
        start   = 1'b0;
        pattern = N'($urandom);
        checks++;
        if (busy_a !== 1'b1 || hc_a !== 5'd0 || any_a !== 1'b0 || fh_a !== 4'hF) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b hc=%0d any=%b fh=%h want 1 0 0 f",
                     busy_a, hc_a, any_a, fh_a);
        end
        lat = -1;
        for (int n = 2; n <= 40; n++) begin
            @(negedge Clock);
            if (done_a === 1'b1) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat != N + 2 || hc_a !== 5'(cnt2) || fh_a !== 4'(f2)) begin
            errors++;
            $display("FAIL b2b_run2 pat=%h: lat=%0d hc=%0d fh=%0d want %0d %0d %0d",
                     p2, lat, hc_a, fh_a, N + 2, cnt2, f2);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clock);
            test_pattern(N'($urandom));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pattern(16'h000F);
        test_pattern(16'h5555);
        test_pattern(16'hFFFF);
        test_pattern(16'h0000);
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
